reg_write_arbiter: RTL and testbench

//  Shares the register file's single write port (control_reg_write / control_write_id /
//  reg_write_value) between NUM_REQ writeback sources, e.g. ALU WB, load WB, syscall return.

---
 rtl/reg_write_arbiter.sv | 131 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ writeback sources.
// Optional macro REG_WR_ARB_STATS_EN builds a saturating counter of discarded id==0 writes.
module reg_write_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 5
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ID_W-1:0]      req_id,
  input  logic [NUM_REQ*DATA_W-1:0]    req_value,
  output logic                         wr_en,
  output logic [ID_W-1:0]              wr_id,
  output logic [DATA_W-1:0]            wr_value,
  output logic [$clog2(NUM_REQ)-1:0]   grant_idx,
  output logic                         busy,
  output logic [15:0]                  drop_count
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] accept;
  logic [NUM_REQ-1:0] id_zero;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   win_next;
  logic [IDX_W-1:0]   scan_idx;
  logic               any_gnt;

  logic [ID_W-1:0]    slot_id  [NUM_REQ];
  logic [DATA_W-1:0]  slot_val [NUM_REQ];

  // Scan pending slots starting at rr_ptr; the first hit wins.
  always_comb begin
    gnt      = '0;
    win      = '0;
    any_gnt  = 1'b0;
    scan_idx = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      scan_idx = IDX_W'((32'(rr_ptr) + off) % NUM_REQ);
      if (!any_gnt && pend[scan_idx]) begin
        any_gnt       = 1'b1;
        win           = scan_idx;
        gnt[scan_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    win_next = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
  end

  always_comb begin
    req_ready = ~pend | gnt;
    accept    = req_valid & req_ready;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      id_zero[k] = (req_id[k*ID_W +: ID_W] == '0);
    end
  end

  assign busy = (|pend) | wr_en;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend      <= '0;
      rr_ptr    <= '0;
      wr_en     <= 1'b0;
      wr_id     <= '0;
      wr_value  <= '0;
      grant_idx <= '0;
    end else begin
      wr_en <= any_gnt;
      if (any_gnt) begin
        wr_id     <= slot_id[win];
        wr_value  <= slot_val[win];
        grant_idx <= win;
        rr_ptr    <= win_next;
      end
      // A reload on the grant edge keeps the slot pending.
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (accept[k] && !id_zero[k]) begin
          pend[k] <= 1'b1;
        end else if (gnt[k]) begin
          pend[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (accept[k] && !id_zero[k]) begin
        slot_id[k]  <= req_id[k*ID_W +: ID_W];
        slot_val[k] <= req_value[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef REG_WR_ARB_STATS_EN
  logic [15:0] drop_cnt;
  logic [3:0]  drop_num;
  logic [16:0] drop_sum;

  always_comb begin
    drop_num = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (accept[k] && id_zero[k]) begin
        drop_num = drop_num + 4'd1;
      end
    end
    drop_sum = {1'b0, drop_cnt} + 17'(drop_num);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: per-cycle comparison against a behavioural model
// plus literal expectations for the documented scenarios.
module tb_reg_write_arbiter;

  localparam int N = 3;
  localparam int DW = 32;
  localparam int IW = 5;

  logic            clock;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*IW-1:0] req_id;
  logic [N*DW-1:0] req_value;
  logic            wr_en;
  logic [IW-1:0]   wr_id;
  logic [DW-1:0]   wr_value;
  logic [1:0]      grant_idx;
  logic            busy;
  logic [15:0]     drop_count;

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 0;

  reg_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_value(req_value),
    .wr_en(wr_en), .wr_id(wr_id), .wr_value(wr_value),
    .grant_idx(grant_idx), .busy(busy), .drop_count(drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural model: slot array, round-robin pointer, registered write beat.
  bit          m_pend [N];
  int          m_id   [N];
  logic [31:0] m_val  [N];
  int          m_rr, m_wid, m_gidx, m_drop, mw;
  bit          m_en;
  logic [31:0] m_wval;
  bit          m_rdy  [N];

  function automatic int m_winner();
    for (int off = 0; off < N; off++)
      if (m_pend[(m_rr + off) % N]) return (m_rr + off) % N;
    return -1;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) m_pend[k] = 0;
      m_rr = 0; m_en = 0; m_wid = 0; m_wval = '0; m_gidx = 0; m_drop = 0;
    end else begin
      mw = m_winner();
      for (int k = 0; k < N; k++) m_rdy[k] = !m_pend[k] || (k == mw);
      if (mw >= 0) begin
        m_en = 1; m_wid = m_id[mw]; m_wval = m_val[mw]; m_gidx = mw;
        m_rr = (mw + 1) % N; m_pend[mw] = 0;
      end else begin
        m_en = 0;
      end
      for (int k = 0; k < N; k++) begin
        if (req_valid[k] && m_rdy[k]) begin
          if (req_id[k*IW +: IW] != 0) begin
            m_pend[k] = 1; m_id[k] = int'(req_id[k*IW +: IW]); m_val[k] = req_value[k*DW +: DW];
          end else begin
`ifdef REG_WR_ARB_STATS_EN
            if (m_drop < 65535) m_drop++;
`endif
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && cmp_en) begin
      logic [N-1:0] exp_rdy;
      bit any_p;
      int w;
      w = m_winner();
      any_p = 0;
      for (int k = 0; k < N; k++) begin
        exp_rdy[k] = !m_pend[k] || (k == w);
        any_p |= m_pend[k];
      end
      check("cyc_wr_en", wr_en, m_en);
      check("cyc_wr_id", wr_id, m_wid);
      check("cyc_wr_value", wr_value, m_wval);
      check("cyc_grant_idx", grant_idx, m_gidx);
      check("cyc_busy", busy, any_p | m_en);
      check("cyc_req_ready", req_ready, exp_rdy);
      check("cyc_drop_count", drop_count, m_drop);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int k, input bit v, input int id, input logic [31:0] val);
    req_valid[k] = v;
    req_id[k*IW +: IW] = IW'(id);
    req_value[k*DW +: DW] = val;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req_valid = '0;
    @(negedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = '0; req_id = '0; req_value = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_req_ready", req_ready, 3'b111);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_idx", grant_idx, 0);
    check("rst_drop", drop_count, 0);
    @(negedge clock);
    #1 reset_n = 1'b1;
    cmp_en = 1;

    // Single write
    set_req(0, 1, 5, 32'hDEADBEEF);
    tick();
    req_valid = '0;
    tick();
    check("t1_wr_en", wr_en, 1);
    check("t1_wr_id", wr_id, 5);
    check("t1_wr_value", wr_value, 32'hDEADBEEF);
    check("t1_grant_idx", grant_idx, 0);
    tick();
    check("t1_idle_wr_en", wr_en, 0);
    check("t1_idle_busy", busy, 0);

    // All three held: grants 0,1,2,0,1,2
    do_reset();
    set_req(0, 1, 1, 32'hA); set_req(1, 1, 2, 32'hB); set_req(2, 1, 3, 32'hC);
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t2_grant_seq", grant_idx, i % 3);
      check("t2_wr_en", wr_en, 1);
      if (i == 0) check("t2_ready_one_hot", req_ready, 3'b010);
    end
    req_valid = '0;
    repeat (4) tick();

    // Wrap: rr_ptr=1 with pend 0 and 2
    do_reset();
    set_req(0, 1, 4, 32'h44);
    tick();
    req_valid = '0;
    repeat (2) tick();
    set_req(0, 1, 9, 32'h99); set_req(2, 1, 10, 32'h1010);
    tick();
    req_valid = '0;
    tick();
    check("t3_first_grant", grant_idx, 2);
    check("t3_first_id", wr_id, 10);
    tick();
    check("t3_second_grant", grant_idx, 0);
    check("t3_second_id", wr_id, 9);
    tick();
    set_req(0, 1, 1, 32'h1); set_req(1, 1, 2, 32'h2); set_req(2, 1, 3, 32'h3);
    tick();
    req_valid = '0;
    tick();
    check("t3_rr_after_wrap", grant_idx, 1);
    repeat (3) tick();

    // id==0 is dropped
    do_reset();
    set_req(1, 1, 0, 32'h7);
    check("t4_ready", req_ready[1], 1);
    tick();
    req_valid = '0;
    check("t4_wr_en", wr_en, 0);
    check("t4_busy", busy, 0);
`ifdef REG_WR_ARB_STATS_EN
    check("t4_drop", drop_count, 1);
`else
    check("t4_drop", drop_count, 0);
`endif
    tick();
    check("t4_wr_en_later", wr_en, 0);

    // Lone requester streams ids 1..8
    for (int j = 0; j <= 8; j++) begin
      if (j < 8) set_req(1, 1, j + 1, 32'h100 + j);
      else req_valid = '0;
      tick();
      if (j >= 1) begin
        check("t5_wr_en", wr_en, 1);
        check("t5_wr_id", wr_id, j);
      end
    end
    tick();
    check("t5_done", wr_en, 0);

    // Reset mid-operation
    do_reset();
    set_req(0, 1, 4, 32'h4); set_req(1, 1, 5, 32'h5); set_req(2, 1, 6, 32'h6);
    tick();
    tick();
    check("t6_active", wr_en, 1);
    check("t6_busy_active", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_wr_en", wr_en, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_ready", req_ready, 3'b111);
    req_valid = '0;
    @(negedge clock);
    #1 reset_n = 1'b1;
    check("t6_busy_after", busy, 0);
    set_req(0, 1, 7, 32'h7); set_req(1, 1, 8, 32'h8); set_req(2, 1, 9, 32'h9);
    tick();
    req_valid = '0;
    tick();
    check("t6_first_grant", grant_idx, 0);
    check("t6_first_id", wr_id, 7);
    repeat (3) tick();

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
